// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access
// sizes, RV32I funct3 encodings and the latched request record.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } lsu_size_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // Number of bytes touched by an access; 0 for the illegal size.
    function automatic logic [2:0] size_bytes(lsu_size_e size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            SIZE_W:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Lane mask of an access starting at lane 0.
    function automatic logic [3:0] size_mask(lsu_size_e size);
        case (size)
            SIZE_B:  return 4'b0001;
            SIZE_H:  return 4'b0011;
            SIZE_W:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // True when the access spills over into the next word.
    function automatic logic crosses(logic [1:0] off, lsu_size_e size);
        return ({1'b0, off} + size_bytes(size)) > 3'd4;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the load/store unit: per-beat byte enables and write
// data, and the load path that right-justifies and extends merged bytes.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  lsu_size_e   size,
    input  logic        is_unsigned,
    input  logic        beat,
    input  logic [31:0] store_data,
    input  logic [63:0] merge,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  be_wide;
    logic [63:0] wdata_wide;
    logic [31:0] shifted;

    // Shift mask and data across a two-word window; the upper word is beat 1.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        be         = '0;
        wdata      = '0;
        load_data  = '0;
        be_wide    = {4'b0000, size_mask(size)} << off;
        wdata_wide = {32'h0, store_data} << {off, 3'b000};
        shifted    = 32'(merge >> {off, 3'b000});

        be    = beat ? be_wide[7:4]     : be_wide[3:0];
        wdata = beat ? wdata_wide[63:32] : wdata_wide[31:0];

        case (size)
            SIZE_B:  load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_H:  load_data = is_unsigned ? {16'h0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage initiator: takes one load/store from the pipeline, drives a
// word-aligned req/gnt/rvalid port (two beats for word-crossing accesses),
// and returns a single extended response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state, state_next;
    lsu_req_t    req_q;
    logic [63:0] merge_q, merge_next;

    logic        accept;
    lsu_size_e   in_size;
    logic        in_err;
    lsu_size_e   q_size;
    logic        q_split;
    logic        beat;
    logic [3:0]  beat_be;
    logic [31:0] beat_wdata;
    logic [31:0] load_data;

    assign accept  = req_valid & req_ready;
    assign in_size = lsu_size_e'(req_funct3[1:0]);
    assign in_err  = (in_size == SIZE_X)
                   | (req_we & req_funct3[2])
                   | (crosses(req_addr[1:0], in_size) & ~MISALIGN_SPLIT);

    assign q_size  = lsu_size_e'(req_q.funct3[1:0]);
    assign q_split = MISALIGN_SPLIT & crosses(req_q.addr[1:0], q_size);

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

    // The port is driven straight from state so reset drops mem_req at once;
    // outside a request phase every port field reads zero.
    assign beat      = (state == REQ1);
    assign mem_req   = (state == REQ0) | (state == REQ1);
    assign mem_we    = mem_req & req_q.we;
    assign mem_addr  = mem_req ? (req_q.addr[31:2] + {29'h0, beat}) : '0;
    assign mem_be    = mem_req ? beat_be : '0;
    assign mem_wdata = mem_req ? beat_wdata : '0;

    lsu_align u_align (
        .off         (req_q.addr[1:0]),
        .size        (q_size),
        .is_unsigned (req_q.funct3[2]),
        .beat        (beat),
        .store_data  (req_q.wdata),
        .merge       (merge_next),
        .be          (beat_be),
        .wdata       (beat_wdata),
        .load_data   (load_data)
    );

    // Next-state logic and capture of returning read beats into the merge window.
    always_comb begin
        state_next = state;
        merge_next = merge_q;
        case (state)
            IDLE:  if (accept) state_next = in_err ? RESP : REQ0;
            REQ0:  if (mem_gnt) state_next = WAIT0;
            WAIT0: if (mem_rvalid) begin
                       merge_next = {32'h0, mem_rdata};
                       state_next = q_split ? REQ1 : RESP;
                   end
            REQ1:  if (mem_gnt) state_next = WAIT1;
            WAIT1: if (mem_rvalid) begin
                       merge_next = {mem_rdata, merge_q[31:0]};
                       state_next = RESP;
                   end
            RESP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, latched request, merge window and held response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_q     <= '0;
            merge_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state   <= state_next;
            merge_q <= merge_next;
            if (accept) begin
                req_q   <= '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
                merge_q <= '0;
            end
            // Response fields load only when entering RESP and hold until the next one.
            if (state_next == RESP && state != RESP) begin
                rsp_err   <= (state == IDLE);
                rsp_rdata <= (state == IDLE || req_q.we) ? 32'h0 : load_data;
            end
        end
    end

endmodule
